// File: rtl/lcd_ctrl.sv
// lcd_ctrl: image-processing controller for an 8x8 frame of 8-bit pixels.
// After reset it copies the whole image ROM into a local 64x8 buffer. It then
// executes 3-bit commands on a 2x2 window anchored at the operation point
// (x, y), with both coordinates in 1..7. The window's bottom-right pixel is at
// y*8+x. Write (cmd 0) streams the buffer out to the IRB memory and pulses done.
//
// Ports:
//   clk        clock, all state changes on the rising edge
//   reset      synchronous, active-high; aborts any operation and restarts LOAD
//   IROM_Q     ROM read data, valid the cycle after an address is read
//   cmd        command code (0 write, 1-4 shift, 5 average, 6/7 mirror)
//   cmd_valid  command qualifier, only sampled while busy=0
//   IROM_EN    ROM chip enable, active-low
//   IROM_A     ROM address
//   IRB_RW     IRB write strobe, active-low
//   IRB_D      IRB write data
//   IRB_A      IRB address
//   busy       1 while a command (or the initial load) is in progress
//   done       one-cycle pulse after the last IRB write of a Write command
module lcd_ctrl (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] IROM_Q,
  input  logic [2:0] cmd,
  input  logic       cmd_valid,
  output logic       IROM_EN,
  output logic [5:0] IROM_A,
  output logic       IRB_RW,
  output logic [7:0] IRB_D,
  output logic [5:0] IRB_A,
  output logic       busy,
  output logic       done
);

  typedef enum logic [2:0] {S_LOAD, S_LTAIL, S_IDLE, S_EXEC, S_WRITE} state_t;

  state_t     state_q, state_d;
  logic       irom_en_q, irom_en_d;
  logic [5:0] irom_a_q, irom_a_d;
  logic       rd_vld_q, rd_vld_d;
  logic [5:0] rd_a_q, rd_a_d;
  logic       irb_rw_q, irb_rw_d;
  logic [5:0] irb_a_q, irb_a_d;
  logic [7:0] irb_d_q, irb_d_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic [2:0] cmd_q, cmd_d;
  logic [2:0] px_q, px_d;
  logic [2:0] py_q, py_d;

  logic [7:0] pix_q [64];

  logic [5:0] w_tl, w_tr, w_bl, w_br;
  logic [5:0] irb_a_nxt;
  logic [7:0] avg_v;

  function automatic logic [2:0] sat_dec(input logic [2:0] v);
    return (v == 3'd1) ? 3'd1 : v - 3'd1;
  endfunction

  function automatic logic [2:0] sat_inc(input logic [2:0] v);
    return (v == 3'd7) ? 3'd7 : v + 3'd1;
  endfunction

  // Truncating mean of four pixels; the 10-bit sum cannot overflow.
  function automatic logic [7:0] avg4(input logic [7:0] a, input logic [7:0] b,
                                      input logic [7:0] c, input logic [7:0] d);
    logic [9:0] s;
    s = {2'b00, a} + {2'b00, b} + {2'b00, c} + {2'b00, d};
    return s[9:2];
  endfunction

  // Row-major addressing makes each window address a plain {row, col} concat.
  always_comb begin
    w_tl      = {py_q - 3'd1, px_q - 3'd1};
    w_tr      = {py_q - 3'd1, px_q};
    w_bl      = {py_q, px_q - 3'd1};
    w_br      = {py_q, px_q};
    irb_a_nxt = irb_a_q + 6'd1;
    avg_v     = avg4(pix_q[w_tl], pix_q[w_tr], pix_q[w_bl], pix_q[w_br]);
  end

  always_comb begin
    state_d   = state_q;
    irom_en_d = irom_en_q;
    irom_a_d  = irom_a_q;
    rd_vld_d  = 1'b0;
    rd_a_d    = rd_a_q;
    irb_rw_d  = irb_rw_q;
    irb_a_d   = irb_a_q;
    irb_d_d   = irb_d_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    cmd_d     = cmd_q;
    px_d      = px_q;
    py_d      = py_q;
    case (state_q)
      S_LOAD: begin
        if (irom_en_q) begin
          // First cycle after reset: start reading from address 0.
          irom_en_d = 1'b0;
          irom_a_d  = 6'd0;
        end else begin
          // The address read this cycle returns data next cycle; remember it.
          rd_vld_d = 1'b1;
          rd_a_d   = irom_a_q;
          if (irom_a_q == 6'd63) begin
            irom_en_d = 1'b1;
            state_d   = S_LTAIL;
          end else begin
            irom_a_d = irom_a_q + 6'd1;
          end
        end
      end
      S_LTAIL: begin
        // Pixel 63 lands in the buffer on this edge.
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      S_IDLE: begin
        if (!busy_q && cmd_valid) begin
          cmd_d  = cmd;
          busy_d = 1'b1;
          if (cmd == 3'd0) begin
            irb_rw_d = 1'b0;
            irb_a_d  = 6'd0;
            irb_d_d  = pix_q[6'd0];
            state_d  = S_WRITE;
          end else begin
            state_d = S_EXEC;
          end
        end
      end
      S_EXEC: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
        case (cmd_q)
          3'd1:    py_d = sat_dec(py_q);
          3'd2:    py_d = sat_inc(py_q);
          3'd3:    px_d = sat_dec(px_q);
          3'd4:    px_d = sat_inc(px_q);
          default: ;
        endcase
      end
      S_WRITE: begin
        if (irb_a_q == 6'd63) begin
          irb_rw_d = 1'b1;
          done_d   = 1'b1;
          busy_d   = 1'b0;
          state_d  = S_IDLE;
        end else begin
          irb_a_d = irb_a_nxt;
          irb_d_d = pix_q[irb_a_nxt];
        end
      end
      default: state_d = S_LOAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_LOAD;
      irom_en_q <= 1'b1;
      irom_a_q  <= 6'd0;
      rd_vld_q  <= 1'b0;
      rd_a_q    <= 6'd0;
      irb_rw_q  <= 1'b1;
      irb_a_q   <= 6'd0;
      irb_d_q   <= 8'd0;
      busy_q    <= 1'b1;
      done_q    <= 1'b0;
      cmd_q     <= 3'd0;
      px_q      <= 3'd4;
      py_q      <= 3'd4;
    end else begin
      state_q   <= state_d;
      irom_en_q <= irom_en_d;
      irom_a_q  <= irom_a_d;
      rd_vld_q  <= rd_vld_d;
      rd_a_q    <= rd_a_d;
      irb_rw_q  <= irb_rw_d;
      irb_a_q   <= irb_a_d;
      irb_d_q   <= irb_d_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      cmd_q     <= cmd_d;
      px_q      <= px_d;
      py_q      <= py_d;
    end
  end

  // Pixel buffer: ROM capture during load, window rewrites during EXEC.
  always_ff @(posedge clk) begin
    if (rd_vld_q) pix_q[rd_a_q] <= IROM_Q;
    if (!reset && state_q == S_EXEC) begin
      case (cmd_q)
        3'd5: begin
          pix_q[w_tl] <= avg_v;
          pix_q[w_tr] <= avg_v;
          pix_q[w_bl] <= avg_v;
          pix_q[w_br] <= avg_v;
        end
        3'd6: begin
          pix_q[w_tl] <= pix_q[w_bl];
          pix_q[w_bl] <= pix_q[w_tl];
          pix_q[w_tr] <= pix_q[w_br];
          pix_q[w_br] <= pix_q[w_tr];
        end
        3'd7: begin
          pix_q[w_tl] <= pix_q[w_tr];
          pix_q[w_tr] <= pix_q[w_tl];
          pix_q[w_bl] <= pix_q[w_br];
          pix_q[w_br] <= pix_q[w_bl];
        end
        default: ;
      endcase
    end
  end

  assign IROM_EN = irom_en_q;
  assign IROM_A  = irom_a_q;
  assign IRB_RW  = irb_rw_q;
  assign IRB_D   = irb_d_q;
  assign IRB_A   = irb_a_q;
  assign busy    = busy_q;
  assign done    = done_q;

endmodule

// File: tb/tb_lcd_ctrl.sv
// Bench for lcd_ctrl: ROM holds pixel k = k, IRB is a simple memory model.
module tb_lcd_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] IROM_Q;
  logic [2:0] cmd;
  logic       cmd_valid;
  logic       IROM_EN;
  logic [5:0] IROM_A;
  logic       IRB_RW;
  logic [7:0] IRB_D;
  logic [5:0] IRB_A;
  logic       busy;
  logic       done;

  int tests = 0;
  int fails = 0;

  // Reference model: image and operation point.
  int img [64];
  int mx, my;

  // IRB memory with a generation tag so stale contents are detectable.
  int ram [64];
  int ram_gen [64];
  int gen = 0;

  // Compare-process state.
  int load_idx = 0;
  int wr_idx = 0;
  bit exp_done = 1'b0;
  bit loading = 1'b1;
  int done_cnt = 0;

  always #5 clk = ~clk;

  lcd_ctrl dut (
    .clk(clk), .reset(reset), .IROM_Q(IROM_Q), .cmd(cmd), .cmd_valid(cmd_valid),
    .IROM_EN(IROM_EN), .IROM_A(IROM_A), .IRB_RW(IRB_RW), .IRB_D(IRB_D),
    .IRB_A(IRB_A), .busy(busy), .done(done)
  );

  // Synchronous ROM: pixel k holds value k.
  always_ff @(posedge clk) begin
    if (!IROM_EN) IROM_Q <= {2'b00, IROM_A};
  end

  initial begin
    for (int i = 0; i < 64; i++) begin
      ram[i] = 0;
      ram_gen[i] = -1;
    end
    forever begin
      @(posedge clk);
      if (IRB_RW == 1'b0) begin
        ram[IRB_A] = int'(IRB_D);
        ram_gen[IRB_A] = gen;
      end
    end
  end

  function automatic void check(input bit ok, input string name, input int act, input int exp);
    tests++;
    if (!ok) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endfunction

  // Per-cycle compare against the model.
  initial begin
    forever begin
      @(negedge clk);
      if (reset) begin
        load_idx = 0;
        wr_idx = 0;
        exp_done = 1'b0;
        loading = 1'b1;
      end else begin
        if (!IROM_EN) begin
          check(int'(IROM_A) == load_idx, "load_addr", int'(IROM_A), load_idx);
          load_idx++;
        end
        if (loading && !busy) begin
          check(load_idx == 64, "load_count", load_idx, 64);
          loading = 1'b0;
        end
        check(done == exp_done, "done_timing", int'(done), int'(exp_done));
        if (done) done_cnt++;
        exp_done = 1'b0;
        if (!IRB_RW) begin
          check(int'(IRB_A) == wr_idx, "irb_addr", int'(IRB_A), wr_idx);
          check(int'(IRB_D) == img[wr_idx % 64], $sformatf("irb_data[%0d]", wr_idx),
                int'(IRB_D), img[wr_idx % 64]);
          check(busy == 1'b1, "busy_in_write", int'(busy), 1);
          if (wr_idx == 63) begin
            exp_done = 1'b1;
            wr_idx = 0;
          end else begin
            wr_idx++;
          end
        end
      end
    end
  end

  task automatic model_reset();
    for (int i = 0; i < 64; i++) img[i] = i;
    mx = 4;
    my = 4;
  endtask

  task automatic model_apply(input int c);
    int tl, tr, bl, br, t, s;
    tl = (my - 1) * 8 + (mx - 1);
    tr = (my - 1) * 8 + mx;
    bl = my * 8 + (mx - 1);
    br = my * 8 + mx;
    case (c)
      1: my = (my > 1) ? my - 1 : 1;
      2: my = (my < 7) ? my + 1 : 7;
      3: mx = (mx > 1) ? mx - 1 : 1;
      4: mx = (mx < 7) ? mx + 1 : 7;
      5: begin
        s = (img[tl] + img[tr] + img[bl] + img[br]) / 4;
        img[tl] = s; img[tr] = s; img[bl] = s; img[br] = s;
      end
      6: begin
        t = img[tl]; img[tl] = img[bl]; img[bl] = t;
        t = img[tr]; img[tr] = img[br]; img[br] = t;
      end
      7: begin
        t = img[tl]; img[tl] = img[tr]; img[tr] = t;
        t = img[bl]; img[bl] = img[br]; img[br] = t;
      end
      default: ;
    endcase
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 2000) begin
      @(posedge clk); #1;
      n++;
    end
    if (busy) check(1'b0, "wait_idle_timeout", int'(busy), 0);
  endtask

  task automatic reset_dut();
    reset = 1'b1;
    cmd_valid = 1'b0;
    cmd = 3'd0;
    repeat (2) begin @(posedge clk); #1; end
    check(IROM_EN == 1'b1 && IROM_A == 6'd0, "rst_irom", {IROM_EN, IROM_A}, 64);
    check(IRB_RW == 1'b1 && IRB_A == 6'd0 && IRB_D == 8'd0, "rst_irb",
          {IRB_RW, IRB_A, IRB_D}, 16384);
    check(busy == 1'b1 && done == 1'b0, "rst_busy_done", {busy, done}, 2);
    reset = 1'b0;
    model_reset();
  endtask

  task automatic issue(input int c);
    wait_idle();
    cmd = 3'(c);
    cmd_valid = 1'b1;
    model_apply(c);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    check(busy == 1'b1, $sformatf("busy_after_cmd%0d", c), int'(busy), 1);
  endtask

  task automatic do_write();
    int n = 0;
    gen++;
    issue(0);
    while (!done && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    check(done == 1'b1, "done_seen", int'(done), 1);
    check(busy == 1'b0, "busy_at_done", int'(busy), 0);
    for (int i = 0; i < 64; i++)
      check(ram_gen[i] == gen && ram[i] == img[i], $sformatf("ram_vs_model[%0d]", i),
            ram[i], img[i]);
    @(posedge clk); #1;
    check(done == 1'b0, "done_one_cycle", int'(done), 0);
  endtask

  task automatic chk_ram(input int a, input int exp);
    check(ram_gen[a] == gen && ram[a] == exp, $sformatf("ram_lit[%0d]", a), ram[a], exp);
  endtask

  initial begin
    int dc;
    reset = 1'b1;
    cmd = 3'd0;
    cmd_valid = 1'b0;

    // Plain load + write.
    reset_dut();
    dc = done_cnt;
    do_write();
    chk_ram(0, 0); chk_ram(27, 27); chk_ram(63, 63);
    check(done_cnt - dc == 1, "done_pulse_count", done_cnt - dc, 1);

    // Average at (4,4).
    reset_dut();
    issue(5);
    do_write();
    chk_ram(27, 31); chk_ram(28, 31); chk_ram(35, 31); chk_ram(36, 31);
    chk_ram(26, 26); chk_ram(37, 37);

    // Mirror X at (4,4).
    reset_dut();
    issue(6);
    do_write();
    chk_ram(27, 35); chk_ram(28, 36); chk_ram(35, 27); chk_ram(36, 28);

    // Saturate at (1,1), then Mirror Y.
    reset_dut();
    repeat (4) issue(1);
    repeat (4) issue(3);
    issue(7);
    do_write();
    chk_ram(0, 1); chk_ram(1, 0); chk_ram(8, 9); chk_ram(9, 8);

    // Saturate at (7,7), then Average.
    reset_dut();
    repeat (5) issue(4);
    repeat (5) issue(2);
    issue(5);
    do_write();
    chk_ram(54, 58); chk_ram(55, 58); chk_ram(62, 58); chk_ram(63, 58);

    // Continuous cmd_valid with a 45-command stream.
    reset_dut();
    wait_idle();
    cmd_valid = 1'b1;
    for (int i = 0; i < 45; i++) begin
      int c;
      c = 1 + ((i * 5 + i / 3) % 7);
      wait_idle();
      cmd = 3'(c);
      model_apply(c);
      @(posedge clk); #1;
      if (i == 44) cmd_valid = 1'b0;
      check(busy == 1'b1, $sformatf("stream_accept[%0d]", i), int'(busy), 1);
    end
    do_write();

    // Reset in the middle of a Write.
    dc = done_cnt;
    issue(0);
    repeat (10) begin @(posedge clk); #1; end
    reset = 1'b1;
    @(posedge clk); #1;
    check(IROM_EN == 1'b1 && IROM_A == 6'd0, "midwr_rst_irom", {IROM_EN, IROM_A}, 64);
    check(IRB_RW == 1'b1 && done == 1'b0 && busy == 1'b1, "midwr_rst_ctl",
          {IRB_RW, done, busy}, 5);
    reset = 1'b0;
    model_reset();
    @(posedge clk); #1;
    check(IROM_EN == 1'b0 && IROM_A == 6'd0, "reload_start", {IROM_EN, IROM_A}, 0);
    wait_idle();
    check(done_cnt == dc, "no_done_after_abort", done_cnt - dc, 0);
    issue(6);
    do_write();
    chk_ram(27, 35); chk_ram(28, 36); chk_ram(35, 27); chk_ram(36, 28);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/lcd_ctrl.md
Name: lcd_ctrl

Overview:
- Image-processing controller for an 8x8 LCD frame of 8-bit pixels.
- After reset it loads 64 pixels from an image ROM into an internal 64x8 buffer.
- It then executes 3-bit commands on a 2x2 operation window: shift, average and mirror.
- A Write command dumps the buffer into an external image RAM (IRB) and pulses done.

Parameters:
- none; image size fixed at 8x8, pixel width 8, operation-point range 1..7.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high.
- IROM_Q  input  8  ROM read data; valid the cycle after the address is presented with IROM_EN=0.
- cmd  input  3  command code.
- cmd_valid  input  1  cmd qualifier; sampled only when busy=0.
- IROM_EN  output  1  ROM chip enable, active-low.
- IROM_A  output  6  ROM address.
- IRB_RW  output  1  IRB write enable, active-low (0 = write, 1 = idle/read).
- IRB_D  output  8  IRB write data.
- IRB_A  output  6  IRB address.
- busy  output  1  1 = not accepting commands.
- done  output  1  one-cycle pulse after a Write completes.

Behaviour:
- Addressing: address = row*8 + col (row-major).
  - Operation point (x = col, y = row), each in range 1..7.
  - Window = {(y-1)*8+(x-1), (y-1)*8+x, y*8+(x-1), y*8+x}.
- Reset values: busy=1, done=0, IROM_EN=1, IROM_A=0, IRB_RW=1, IRB_A=0, IRB_D=0, point=(4,4), state=LOAD.
- LOAD state:
  - Drive IROM_EN=0 and IROM_A=0..63, one per cycle.
  - Capture IROM_Q one cycle later into buffer[address].
  - After pixel 63 is stored: IROM_EN=1, busy=0, go to IDLE.
- IDLE state:
  - On a rising edge with busy=0 and cmd_valid=1, latch cmd and set busy=1 on that same edge.
  - The environment presents the next command only after observing busy=0 again.
  - Every command holds busy=1 for at least one full cycle.
- Command 0, Write:
  - Drive IRB_RW=0 with IRB_A=k, IRB_D=buffer[k] for k=0..63, one pixel per cycle.
  - The cycle after the last write edge: IRB_RW=1, done=1 for exactly one cycle, busy=0, return to IDLE.
  - The memory must already hold pixel 63 when done rises.
  - Further commands remain legal after a Write.
- Command 1, Shift Up: y=y-1, saturating at 1.
- Command 2, Shift Down: y=y+1, saturating at 7.
- Command 3, Shift Left: x=x-1, saturating at 1.
- Command 4, Shift Right: x=x+1, saturating at 7.
- Command 5, Average:
  - All four window pixels become floor(sum/4).
  - The sum uses a 10-bit adder; no rounding.
- Command 6, Mirror X: swap the top and bottom rows of the window (TL<->BL, TR<->BR).
- Command 7, Mirror Y: swap the left and right columns of the window (TL<->TR, BL<->BR).
- Commands 1-7 complete in one execution cycle: busy=1 for that cycle, then busy=0.
- cmd_valid while busy=1 is ignored; no queuing.
- Shifts at a boundary leave the point unchanged but still occupy a busy cycle.
- Reset asserted mid-LOAD or mid-Write aborts the operation, restores reset values and restarts LOAD. Buffer contents need no reset.
- Output timing: IRB and IROM signals are registered (driven from flops); no combinational path from cmd to outputs.

Test Plan:
- ROM pixel k = k. Reset, wait for busy=0, issue Write -> IRB[k]=k for all 64; done pulses once, one cycle after the last write; busy=0 afterwards.
- Same ROM, Average at (4,4) then Write -> IRB[27], IRB[28], IRB[35], IRB[36] all = 31; all others unchanged.
- Mirror X at (4,4) then Write -> IRB[27]=35, IRB[28]=36, IRB[35]=27, IRB[36]=28.
- Shift Up x4, Shift Left x4, then Mirror Y, then Write:
  - Point saturates at (1,1).
  - Result IRB[0]=1, IRB[1]=0, IRB[8]=9, IRB[9]=8.
- Shift Right x5, Shift Down x5 (point saturates at (7,7)), then Average, then Write -> IRB[54], IRB[55], IRB[62], IRB[63] = floor((54+55+62+63)/4) = 58.
- Hold cmd_valid=1 continuously with a 45-command stream -> exactly one command accepted per busy=0 window. Then assert reset mid-Write -> done stays 0, LOAD restarts (IROM_EN=0, IROM_A=0), point returns to (4,4).
